// File: rtl/fetch_issue_unit.sv
// Fetch/issue front end: owns the fetch PC, issues single-outstanding imem reads,
// and buffers returned words with their PCs for the decode stage.
module fetch_issue_unit #(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        id_ready_i,
  output logic        id_valid_o,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o
);

  localparam int unsigned   AW      = $clog2(BUF_DEPTH);
  localparam logic [31:0]   NOP     = 32'h0000_0013;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } state_e;

  state_e        state_q;
  logic [31:0]   pc_q;
  logic [31:0]   req_pc_q;
  logic [AW:0]   count_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [31:0]   instr_mem_q [BUF_DEPTH];
  logic [31:0]   pc_mem_q    [BUF_DEPTH];

  logic buf_empty;
  logic buf_full;
  logic grant;
  logic push;
  logic pop;

  // Occupancy never exceeds BUF_DEPTH (a power of two), so the count MSB is the full flag.
  assign buf_empty = (count_q == '0);
  assign buf_full  = count_q[AW];

  assign imem_req_o  = !rst_i && (state_q == S_IDLE) && !buf_full && !redirect_i;
  assign imem_addr_o = pc_q;

  assign grant = imem_req_o && imem_gnt_i;
  assign push  = !rst_i && !redirect_i && (state_q == S_WAIT) && imem_rvalid_i;
  assign pop   = !rst_i && !redirect_i && !buf_empty && id_ready_i;

  assign id_valid_o = !buf_empty;
  assign id_instr_o = buf_empty ? NOP   : instr_mem_q[rd_ptr_q];
  assign id_pc_o    = buf_empty ? '0    : pc_mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      pc_q     <= PC_RESET;
      req_pc_q <= '0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else if (redirect_i) begin
      // An in-flight read whose data has not arrived must be swallowed in DROP.
      pc_q     <= {redirect_pc_i[31:2], 2'b00};
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      if (state_q != S_IDLE) begin
        state_q <= imem_rvalid_i ? S_IDLE : S_DROP;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant) begin
            pc_q     <= pc_q + 32'd4;
            req_pc_q <= pc_q;
            state_q  <= S_WAIT;
          end
        end
        S_WAIT, S_DROP: begin
          if (imem_rvalid_i) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_ONE;
      end else if (pop && !push) begin
        count_q <= count_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata_i;
      pc_mem_q[wr_ptr_q]    <= req_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_issue_unit.sv
// Self-checking bench for fetch_issue_unit: a behavioural imem with grant budget and
// programmable read latency, plus grant-address and ID-output scoreboards.
module tb_fetch_issue_unit;

  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_ready_i;
  logic        id_valid_o;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic        w_g  = 1'b0;
  logic        w_rv = 1'b0;
  logic [31:0] w_rdata = 32'h1234_5678;

  always #5 clk = ~clk;

  fetch_issue_unit #(.PC_RESET(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .id_ready_i   (id_ready_i),
    .id_valid_o   (id_valid_o),
    .id_instr_o   (id_instr_o),
    .id_pc_o      (id_pc_o)
  );

  fetch_issue_unit #(.PC_RESET(32'hFFFF_FFFC), .BUF_DEPTH(2)) dut_w (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .imem_req_o   (w_req),
    .imem_addr_o  (w_addr),
    .imem_gnt_i   (1'b1),
    .imem_rvalid_i(w_rv),
    .imem_rdata_i (w_rdata),
    .redirect_i   (1'b0),
    .redirect_pc_i(32'h0),
    .id_ready_i   (1'b1),
    .id_valid_o   (w_valid),
    .id_instr_o   (w_instr),
    .id_pc_o      (w_pc)
  );

  // Memory model: grants until grant_limit is reached, answers rv_lat cycles after the grant cycle.
  int unsigned grant_limit = 0;
  int unsigned rv_lat      = 0;
  int unsigned grants_seen = 0;
  logic        gnt_seen_n  = 1'b0;
  logic [31:0] gnt_addr_n  = '0;
  logic        pend_q      = 1'b0;
  logic [31:0] pend_addr_q = '0;
  int unsigned lat_q       = 0;

  assign imem_gnt_i    = (grants_seen < grant_limit);
  assign imem_rvalid_i = pend_q && (lat_q == 0);
  assign imem_rdata_i  = pend_addr_q ^ KEY;

  always @(negedge clk) begin
    gnt_seen_n <= imem_req_o && imem_gnt_i;
    gnt_addr_n <= imem_addr_o;
    w_g        <= w_req;
  end

  always @(posedge clk) begin
    if (pend_q) begin
      if (lat_q == 0) pend_q <= 1'b0;
      else            lat_q  <= lat_q - 1;
    end
    if (gnt_seen_n) begin
      pend_q      <= 1'b1;
      pend_addr_q <= gnt_addr_n;
      lat_q       <= rv_lat;
    end
    if (rst_i)           grants_seen <= 0;
    else if (gnt_seen_n) grants_seen <= grants_seen + 1;
    w_rv <= w_g;
  end

  logic [31:0] exp_gnt_q [$];
  logic [63:0] exp_pop_q [$];
  int n_checks = 0;
  int n_pass   = 0;

  // One clock: scoreboard checks at the falling edge, then return 2 ns after the rising edge.
  task automatic step;
    logic [31:0] eg;
    logic [63:0] ep;
    @(negedge clk);
    if (!rst_i && imem_req_o && imem_gnt_i) begin
      n_checks++;
      if (exp_gnt_q.size() == 0) begin
        $display("FAIL grant_addr: unexpected grant at %h", imem_addr_o);
      end else begin
        eg = exp_gnt_q.pop_front();
        if (imem_addr_o !== eg) $display("FAIL grant_addr: got %h expected %h", imem_addr_o, eg);
        else n_pass++;
      end
    end
    if (!rst_i && !redirect_i && id_valid_o && id_ready_i) begin
      n_checks++;
      if (exp_pop_q.size() == 0) begin
        $display("FAIL id_pop: unexpected pc=%h instr=%h", id_pc_o, id_instr_o);
      end else begin
        ep = exp_pop_q.pop_front();
        if ({id_pc_o, id_instr_o} !== ep)
          $display("FAIL id_pop: got pc=%h instr=%h expected pc=%h instr=%h",
                   id_pc_o, id_instr_o, ep[63:32], ep[31:0]);
        else n_pass++;
      end
    end
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic rdy, input int unsigned limit);
    rst_i         = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    id_ready_i    = rdy;
    grant_limit   = limit;
    rv_lat        = 0;
    repeat (6) step;
    exp_gnt_q.delete();
    exp_pop_q.delete();
    rst_i = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    int i = 0;
    while ((exp_gnt_q.size() != 0 || exp_pop_q.size() != 0) && i < max_cycles) begin
      step;
      i++;
    end
    n_checks++;
    if (exp_gnt_q.size() != 0 || exp_pop_q.size() != 0)
      $display("FAIL drain_timeout: got %0d grants %0d pops outstanding expected 0 0",
               exp_gnt_q.size(), exp_pop_q.size());
    else n_pass++;
  endtask

  task automatic test_reset;
    rst_i         = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0500;
    id_ready_i    = 1'b1;
    grant_limit   = 0;
    rv_lat        = 0;
    repeat (3) step;
    n_checks++;
    if ({imem_req_o, id_valid_o} !== 2'b00)
      $display("FAIL reset_req_valid: got %b expected 00", {imem_req_o, id_valid_o});
    else n_pass++;
    n_checks++;
    if ({id_instr_o, id_pc_o} !== {NOP, 32'h0})
      $display("FAIL reset_id_out: got instr=%h pc=%h expected %h 0", id_instr_o, id_pc_o, NOP);
    else n_pass++;
    rst_i      = 1'b0;
    redirect_i = 1'b0;
    #1;
    n_checks++;
    if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h0})
      $display("FAIL reset_wins_redirect: got req=%b addr=%h expected 1 0", imem_req_o, imem_addr_o);
    else n_pass++;
  endtask

  task automatic test_basic;
    do_reset(1'b1, 3);
    exp_gnt_q = '{32'h0, 32'h4, 32'h8};
    exp_pop_q = '{{32'h0, 32'hA5A5_0000}, {32'h4, 32'hA5A5_0004}, {32'h8, 32'hA5A5_0008}};
    step;
    n_checks++;
    if (id_valid_o !== 1'b0) $display("FAIL first_latency_early: got %b expected 0", id_valid_o);
    else n_pass++;
    step;
    n_checks++;
    if ({id_valid_o, id_pc_o, id_instr_o} !== {1'b1, 32'h0, 32'hA5A5_0000})
      $display("FAIL first_latency: got v=%b pc=%h instr=%h expected 1 0 a5a50000",
               id_valid_o, id_pc_o, id_instr_o);
    else n_pass++;
    wait_drain(40);
    repeat (2) step;
    n_checks++;
    if ({id_valid_o, imem_req_o, imem_addr_o} !== {2'b01, 32'hC})
      $display("FAIL basic_idle: got v=%b req=%b addr=%h expected 0 1 c",
               id_valid_o, imem_req_o, imem_addr_o);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    do_reset(1'b0, 5);
    exp_gnt_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    exp_pop_q = '{{32'h0, 32'hA5A5_0000}, {32'h4, 32'hA5A5_0004}, {32'h8, 32'hA5A5_0008},
                  {32'hC, 32'hA5A5_000C}, {32'h10, 32'hA5A5_0010}};
    repeat (10) step;
    n_checks++;
    if ({id_valid_o, imem_req_o, id_pc_o, id_instr_o} !== {2'b10, 32'h0, 32'hA5A5_0000})
      $display("FAIL full_hold: got v=%b req=%b pc=%h instr=%h expected 1 0 0 a5a50000",
               id_valid_o, imem_req_o, id_pc_o, id_instr_o);
    else n_pass++;
    n_checks++;
    if (grants_seen !== 2) $display("FAIL full_grants: got %0d expected 2", grants_seen);
    else n_pass++;
    id_ready_i = 1'b1;
    step;
    n_checks++;
    if ({id_valid_o, id_pc_o} !== {1'b1, 32'h4})
      $display("FAIL consecutive_pop: got v=%b pc=%h expected 1 4", id_valid_o, id_pc_o);
    else n_pass++;
    wait_drain(60);
  endtask

  task automatic test_grant_delay;
    int i = 0;
    do_reset(1'b1, 2);
    exp_gnt_q = '{32'h0, 32'h4, 32'h8};
    exp_pop_q = '{{32'h0, 32'hA5A5_0000}, {32'h4, 32'hA5A5_0004}, {32'h8, 32'hA5A5_0008}};
    while (!(grants_seen == 2 && imem_req_o) && i < 20) begin
      step;
      i++;
    end
    for (int c = 0; c < 3; c++) begin
      step;
      n_checks++;
      if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h8})
        $display("FAIL gnt_stall_%0d: got req=%b addr=%h expected 1 8", c, imem_req_o, imem_addr_o);
      else n_pass++;
    end
    grant_limit = 3;
    step;
    n_checks++;
    if ({imem_req_o, imem_addr_o} !== {1'b0, 32'hC})
      $display("FAIL gnt_advance: got req=%b addr=%h expected 0 c", imem_req_o, imem_addr_o);
    else n_pass++;
    step;
    n_checks++;
    if ({imem_req_o, imem_addr_o} !== {1'b1, 32'hC})
      $display("FAIL gnt_once: got req=%b addr=%h expected 1 c", imem_req_o, imem_addr_o);
    else n_pass++;
    wait_drain(40);
  endtask

  task automatic test_redirect_wait;
    int i = 0;
    do_reset(1'b1, 4);
    rv_lat    = 2;
    exp_gnt_q = '{32'h0, 32'h4, 32'h8, 32'h100};
    exp_pop_q = '{{32'h0, 32'hA5A5_0000}, {32'h4, 32'hA5A5_0004}, {32'h100, 32'hA5A5_0100}};
    while (grants_seen != 3 && i < 40) begin
      step;
      i++;
    end
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0100;
    step;
    redirect_i = 1'b0;
    #1;
    n_checks++;
    if ({id_valid_o, imem_req_o, imem_addr_o} !== {2'b00, 32'h100})
      $display("FAIL redirect_wait: got v=%b req=%b addr=%h expected 0 0 100",
               id_valid_o, imem_req_o, imem_addr_o);
    else n_pass++;
    wait_drain(40);
    repeat (2) step;
    n_checks++;
    if (id_valid_o !== 1'b0) $display("FAIL redirect_wait_tail: got %b expected 0", id_valid_o);
    else n_pass++;
  endtask

  task automatic test_redirect_rvalid;
    do_reset(1'b1, 2);
    exp_gnt_q = '{32'h0, 32'h200};
    exp_pop_q = '{{32'h200, 32'hA5A5_0200}};
    step;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0203;
    step;
    redirect_i = 1'b0;
    #1;
    n_checks++;
    if ({id_valid_o, imem_req_o, imem_addr_o} !== {2'b01, 32'h200})
      $display("FAIL redirect_rvalid: got v=%b req=%b addr=%h expected 0 1 200",
               id_valid_o, imem_req_o, imem_addr_o);
    else n_pass++;
    wait_drain(40);
  endtask

  task automatic test_reset_mid_wait;
    int   i = 0;
    logic seen_valid = 1'b0;
    do_reset(1'b1, 2);
    rv_lat    = 3;
    exp_gnt_q = '{32'h0, 32'h4};
    exp_pop_q = '{{32'h0, 32'hA5A5_0000}};
    while (grants_seen != 2 && i < 40) begin
      step;
      i++;
    end
    rst_i       = 1'b1;
    grant_limit = 0;
    step;
    rst_i = 1'b0;
    #1;
    n_checks++;
    if ({id_valid_o, id_instr_o, id_pc_o} !== {1'b0, NOP, 32'h0})
      $display("FAIL mid_wait_reset: got v=%b instr=%h pc=%h expected 0 %h 0",
               id_valid_o, id_instr_o, id_pc_o, NOP);
    else n_pass++;
    repeat (5) begin
      step;
      seen_valid = seen_valid | id_valid_o;
    end
    n_checks++;
    if ({seen_valid, imem_req_o, imem_addr_o} !== {2'b01, 32'h0})
      $display("FAIL late_rvalid: got v=%b req=%b addr=%h expected 0 1 0",
               seen_valid, imem_req_o, imem_addr_o);
    else n_pass++;
    exp_gnt_q.push_back(32'h0);
    exp_pop_q.push_back({32'h0, 32'hA5A5_0000});
    grant_limit = 1;
    wait_drain(40);
  endtask

  task automatic test_pc_wrap;
    do_reset(1'b1, 0);
    #1;
    n_checks++;
    if ({w_req, w_addr} !== {1'b1, 32'hFFFF_FFFC})
      $display("FAIL wrap_first: got req=%b addr=%h expected 1 fffffffc", w_req, w_addr);
    else n_pass++;
    step;
    n_checks++;
    if ({w_req, w_addr} !== {1'b0, 32'h0})
      $display("FAIL wrap_pc: got req=%b addr=%h expected 0 0", w_req, w_addr);
    else n_pass++;
    step;
    n_checks++;
    if ({w_valid, w_pc, w_instr, w_req, w_addr} !== {1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 1'b1, 32'h0})
      $display("FAIL wrap_second: got v=%b pc=%h instr=%h req=%b addr=%h expected 1 fffffffc 12345678 1 0",
               w_valid, w_pc, w_instr, w_req, w_addr);
    else n_pass++;
  endtask

  initial begin
    rst_i         = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    id_ready_i    = 1'b0;
    test_reset;
    test_basic;
    test_backpressure;
    test_grant_delay;
    test_redirect_wait;
    test_redirect_rvalid;
    test_reset_mid_wait;
    test_pc_wrap;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
